gearbox_rx_sync: RTL
====================

GEARBOX_RX_SYNC -- requirements
Module: gearbox_rx_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning PMA input width; legal values 16, 32, 64.
REQ-002 SHALL have parameter HEAD_W, default 2, meaning sync header width.
REQ-003 SHALL have parameter LOCK_N, default 64, meaning consecutive valid headers needed to declare lock.
REQ-004 SHALL have parameter WIN_N, default 64, meaning headers per bad-header window while locked.
REQ-005 SHALL have parameter INV_MAX, default 16, meaning invalid headers per window that force loss of lock.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have clk, input, 1, the single clock.
REQ-008 SHALL have reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have pma_lock_i, input, 1, PMA data valid and locked.
REQ-010 SHALL have data_i, input, DATA_W, PMA bits; bit 0 is received first.
REQ-011 SHALL have valid_o, output, 1, a block is presented on head_o/data_o.
REQ-012 SHALL have head_o, output, HEAD_W, sync header; bit 0 is received first.
REQ-013 SHALL have data_o, output, 64, block payload.
REQ-014 SHALL have block_lock_o, output, 1, the sync FSM is LOCKED.
REQ-015 SHALL have slip_o, output, 1, one-cycle pulse: a one-bit slip was applied.

Function
REQ-016 SHALL accumulate data_i into a shift buffer (capacity 66+DATA_W-1 bits) with bit count cnt, on every cycle pma_lock_i=1.
REQ-017 SHALL extract the 66 oldest bits as {data,head} whenever cnt>=66 and register them; valid_o is high the following cycle (latency 1).
REQ-018 SHALL, for DATA_W=64, emit exactly 32 blocks per 33 input cycles in steady state, never dropping or duplicating bits.
REQ-019 SHALL treat a header as valid iff head[0]^head[1]=1; it is evaluated once per emitted block.
REQ-020 SHALL implement FSM HUNT and LOCKED; reset state is HUNT.
REQ-021 SHALL, in HUNT, count consecutive valid headers; on an invalid header it clears the count and slips; at LOCK_N valid headers it enters LOCKED.
REQ-022 SHALL, in LOCKED, count headers and invalid headers per WIN_N window; on the INV_MAX-th invalid header it enters HUNT and slips; at window end both counts clear.
REQ-023 SHALL implement a slip by discarding the single oldest buffered bit (cnt decremented by 1, in the same cycle as any input add or block extract); slip_o pulses that cycle.
REQ-024 SHALL ignore a second slip request until at least one further block has been evaluated.
REQ-025 SHALL, when pma_lock_i=0, next cycle clear cnt, valid_o, slip_o and all FSM counters, and force HUNT; data_i is ignored.
REQ-026 SHALL hold head_o/data_o stable when valid_o=0.

Reset
REQ-027 SHALL, on reset, set valid_o=0, head_o=0, data_o=0, block_lock_o=0, slip_o=0, cnt=0, FSM=HUNT, and all counters to 0.
REQ-028 SHALL give reset priority over pma_lock_i and any pending slip, including when reset is asserted mid-block.

Configuration
REQ-029 SHALL, with GEARBOX_RX_SYNC_ERR_CNT_EN defined, add output err_cnt_o (16 bits): a saturating count of invalid headers, cleared by reset or pma_lock_i=0; without the macro, the port and its logic do not exist.

Structure
REQ-030 SHALL take BLOCK_W=66, the header encodings (SYNC_DATA=2'b01, SYNC_CTRL=2'b10) and the FSM state enum from a shared pcs package.
REQ-031 SHALL place the HUNT/LOCKED FSM and its counters in sub-module block_sync; the gearbox buffer stays in gearbox_rx_sync.

Verification
REQ-032 SHALL cover: DATA_W=64, aligned blocks with header 01 -> block_lock_o=1 after 64 blocks; valid_o low exactly 1 of every 33 cycles; data_o matches the sent blocks.
REQ-033 SHALL cover: stream offset by 5 bits -> slip_o pulses until aligned; lock within 66*(LOCK_N+1) blocks; data_o then bit-exact.
REQ-034 SHALL cover: when locked, 15 invalid headers in a 64-header window -> lock held; 16 invalid headers -> block_lock_o=0 and slip_o=1 in the same cycle.
REQ-035 SHALL cover: pma_lock_i dropped for 1 cycle mid-stream -> next cycle valid_o=0, block_lock_o=0; relock after 64 valid headers.
REQ-036 SHALL cover: DATA_W=32, aligned stream -> 16 blocks per 33 cycles, correct data; reset asserted mid-block -> all outputs 0 next cycle.
REQ-037 SHALL cover: with GEARBOX_RX_SYNC_ERR_CNT_EN, 70000 invalid headers -> err_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/gearbox_rx_sync_pkg.sv
// rtl/gearbox_rx_sync_pkg.sv - shared PCS constants, header encodings and block-sync state type
package gearbox_rx_sync_pkg;

  localparam int BLOCK_W = 66;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } sync_state_e;

  // A sync header is legal only when its two bits differ.
  function automatic logic head_valid(input logic [1:0] head);
    return (head == SYNC_DATA) || (head == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_sync.sv
// rtl/block_sync.sv - HUNT/LOCKED block synchroniser with header run and bad-header window counters
module block_sync #(
  parameter int LOCK_N  = 64,
  parameter int WIN_N   = 64,
  parameter int INV_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic eval,
  input  logic head_ok,
  output logic locked,
  output logic slip
);
  import gearbox_rx_sync_pkg::*;

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam int WIN_W = $clog2(WIN_N + 1);
  localparam int INV_W = $clog2(INV_MAX + 1);

  sync_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [INV_W-1:0] inv_q, inv_d;

  // State and counter registers; loss of PMA lock behaves like a reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_HUNT;
      run_q   <= '0;
      win_q   <= '0;
      inv_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      inv_q   <= inv_d;
    end
  end

  // Next state: one header evaluated per eval; a slip is requested only by an
  // evaluation and is applied at that same edge, so two slips are always
  // separated by at least one further evaluated block.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    inv_d   = inv_q;
    slip    = 1'b0;
    if (eval) begin
      case (state_q)
        ST_HUNT: begin
          if (head_ok) begin
            if (run_q == RUN_W'(LOCK_N - 1)) begin
              state_d = ST_LOCKED;
              run_d   = '0;
              win_d   = '0;
              inv_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
            slip  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!head_ok && (inv_q == INV_W'(INV_MAX - 1))) begin
            state_d = ST_HUNT;
            run_d   = '0;
            win_d   = '0;
            inv_d   = '0;
            slip    = 1'b1;
          end else if (win_q == WIN_W'(WIN_N - 1)) begin
            win_d = '0;
            inv_d = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
            inv_d = inv_q + INV_W'(!head_ok);
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/gearbox_rx_sync.sv
// rtl/gearbox_rx_sync.sv - RX gearbox to 66-bit blocks with bit slip; GEARBOX_RX_SYNC_ERR_CNT_EN adds err_cnt_o
module gearbox_rx_sync #(
  parameter int DATA_W  = 64,
  parameter int HEAD_W  = 2,
  parameter int LOCK_N  = 64,
  parameter int WIN_N   = 64,
  parameter int INV_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pma_lock_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [63:0]       data_o,
  output logic              block_lock_o,
  output logic              slip_o
`ifdef GEARBOX_RX_SYNC_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt_o
`endif
);
  import gearbox_rx_sync_pkg::*;

  // Buffer holds the leftover of one block plus one input word; bit 0 is oldest.
  localparam int BUF_W = BLOCK_W + DATA_W - 1;
  localparam int CMB_W = BUF_W + DATA_W;
  localparam int CNT_W = $clog2(CMB_W + 1);

  logic [BUF_W-1:0]   sbuf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BUF_W-1:0]   sbuf_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   drop;
  logic [BLOCK_W-1:0] blk;
  logic               take;
  logic               eval;
  logic               head_ok;
  logic               slip_req;

  // Append the new word above the buffered bits, then discard the extracted
  // block and, on a slip, the single oldest bit that follows it.
  always_comb begin
    take      = (cnt_q >= CNT_W'(BLOCK_W));
    blk       = sbuf_q[BLOCK_W-1:0];
    head_ok   = head_valid(blk[1:0]);
    eval      = pma_lock_i && take;
    drop      = (take ? CNT_W'(BLOCK_W) : '0) + (slip_req ? CNT_W'(1) : '0);
    sbuf_next = BUF_W'(({{DATA_W{1'b0}}, sbuf_q} | (CMB_W'(data_i) << cnt_q)) >> drop);
    cnt_next  = cnt_q + CNT_W'(DATA_W) - drop;
  end

  // Buffer, bit count and registered block outputs; head/data hold between blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      sbuf_q  <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
      data_o  <= '0;
      slip_o  <= 1'b0;
    end else if (!pma_lock_i) begin
      sbuf_q  <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      slip_o  <= 1'b0;
    end else begin
      sbuf_q  <= sbuf_next;
      cnt_q   <= cnt_next;
      valid_o <= take;
      slip_o  <= slip_req;
      if (take) begin
        head_o <= blk[HEAD_W-1:0];
        data_o <= blk[BLOCK_W-1:HEAD_W];
      end
    end
  end

  block_sync #(
    .LOCK_N  (LOCK_N),
    .WIN_N   (WIN_N),
    .INV_MAX (INV_MAX)
  ) u_block_sync (
    .clk     (clk),
    .reset   (reset),
    .clear   (!pma_lock_i),
    .eval    (eval),
    .head_ok (head_ok),
    .locked  (block_lock_o),
    .slip    (slip_req)
  );

`ifdef GEARBOX_RX_SYNC_ERR_CNT_EN
  // Saturating count of invalid headers since reset or last PMA lock loss.
  always_ff @(posedge clk) begin
    if (reset || !pma_lock_i) begin
      err_cnt_o <= '0;
    end else if (eval && !head_ok && (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule
